// File: rtl/dds_wave_engine.sv
// dds_wave_engine
//   Phase-accumulator waveform generator for the DDS output path. Each accepted sample
//   tick (Enable & Ready) advances the accumulator by the tuning word that Mode[3:2]
//   selects. The phase is mapped to a sawtooth, square, triangle or midscale word.
//   A mode change waits for a phase wrap (DRAIN) so the waveform never breaks mid-period.
//   A drain timeout forces the switch if no wrap arrives in time.
//
// Ports
//   Fg_CLK   in   system clock
//   RESETn   in   asynchronous active-low reset
//   Enable   in   single-cycle sample tick
//   Ready    in   1 = ticks accepted, 0 = engine frozen
//   Mode     in   [1:0] 00 saw, 01 square, 10 triangle, 11 off; [3:2] tuning-word select
//   Sample   out  unsigned amplitude word, updated one cycle after each tick
//   Valid    out  one-cycle strobe marking a new Sample
//   Busy     out  high while a mode change is pending
//   ModeAck  out  one-cycle pulse when a new mode becomes active
//
// Build option
//   DDS_DITHER_EN : when defined, a 16-bit Galois LFSR adds sub-LSB dither to the
//   waveform-map input only. The stored phase is never changed.

module dds_wave_engine #(
    parameter int unsigned      ACC_W    = 32,
    parameter int unsigned      DATA_W   = 12,
    parameter logic [ACC_W-1:0] TW0      = 32'h0100_0000,
    parameter logic [ACC_W-1:0] TW1      = 32'h0200_0000,
    parameter logic [ACC_W-1:0] TW2      = 32'h0400_0000,
    parameter logic [ACC_W-1:0] TW3      = 32'h0800_0000,
    parameter int unsigned      DRAIN_TO = 1024
) (
    input  logic              Fg_CLK,
    input  logic              RESETn,
    input  logic              Enable,
    input  logic              Ready,
    input  logic [3:0]        Mode,
    output logic [DATA_W-1:0] Sample,
    output logic              Valid,
    output logic              Busy,
    output logic              ModeAck
);

    localparam int unsigned CNT_W = (DRAIN_TO > 1) ? $clog2(DRAIN_TO) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_TO - 1);

    typedef enum logic [0:0] {StRun, StDrain} state_t;

    state_t            state;
    logic [ACC_W-1:0]  acc;
    logic [3:0]        active_mode;
    logic [CNT_W-1:0]  drain_cnt;
    logic              tick_dly;

    logic              tick;
    logic [ACC_W-1:0]  tw;
    logic [ACC_W:0]    sum;
    logic              mode_diff;
    logic              switch_now;
    logic [ACC_W-1:0]  map_in;
    logic [DATA_W-1:0] wave;

    assign tick      = Enable & Ready;
    assign mode_diff = (Mode != active_mode);

    always_comb begin
        tw = TW0;
        case (active_mode[3:2])
            2'b00:   tw = TW0;
            2'b01:   tw = TW1;
            2'b10:   tw = TW2;
            default: tw = TW3;
        endcase
    end

    // The extra top bit of the sum is the wrap (carry-out) flag.
    assign sum        = {1'b0, acc} + {1'b0, tw};
    assign switch_now = sum[ACC_W] | (drain_cnt == CNT_LAST);

`ifdef DDS_DITHER_EN
    localparam int unsigned DITH_W    = (ACC_W - DATA_W - 1 > 16) ? 16 : (ACC_W - DATA_W - 1);
    localparam logic [15:0] DITH_MASK = 16'((32'd1 << DITH_W) - 32'd1);

    logic [15:0] lfsr;

    // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
    always_ff @(posedge Fg_CLK or negedge RESETn) begin
        if (!RESETn) begin
            lfsr <= 16'hACE1;
        end else if (tick) begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    assign map_in = acc + ACC_W'(lfsr & DITH_MASK);
`else
    assign map_in = acc;
`endif

    always_comb begin
        wave = '0;
        case (active_mode[1:0])
            2'b00:   wave = map_in[ACC_W-1 -: DATA_W];
            2'b01:   wave = {DATA_W{map_in[ACC_W-1]}};
            2'b10:   wave = map_in[ACC_W-1] ? ~map_in[ACC_W-2 -: DATA_W]
                                            :  map_in[ACC_W-2 -: DATA_W];
            default: wave = {1'b1, {(DATA_W-1){1'b0}}};
        endcase
    end

    always_ff @(posedge Fg_CLK or negedge RESETn) begin
        if (!RESETn) begin
            state       <= StRun;
            acc         <= '0;
            active_mode <= 4'b0000;
            drain_cnt   <= '0;
            tick_dly    <= 1'b0;
            Sample      <= '0;
            Valid       <= 1'b0;
            Busy        <= 1'b0;
            ModeAck     <= 1'b0;
        end else begin
            // Output stage: Sample follows the phase that the previous tick produced.
            tick_dly <= tick;
            Valid    <= tick_dly;
            ModeAck  <= 1'b0;
            if (tick_dly) begin
                Sample <= wave;
            end

            // With Ready low, phase, state, mode and drain count are all frozen.
            if (Ready) begin
                case (state)
                    StRun: begin
                        if (mode_diff) begin
                            if (active_mode[1:0] == 2'b11) begin
                                // Midscale output has no period to protect.
                                active_mode <= Mode;
                                acc         <= '0;
                                ModeAck     <= 1'b1;
                            end else begin
                                state     <= StDrain;
                                Busy      <= 1'b1;
                                drain_cnt <= '0;
                                if (tick) begin
                                    acc <= sum[ACC_W-1:0];
                                end
                            end
                        end else if (tick) begin
                            acc <= sum[ACC_W-1:0];
                        end
                    end

                    StDrain: begin
                        if (!mode_diff) begin
                            // Request withdrawn: resume with the phase untouched.
                            state <= StRun;
                            Busy  <= 1'b0;
                            if (tick) begin
                                acc <= sum[ACC_W-1:0];
                            end
                        end else if (tick) begin
                            if (switch_now) begin
                                // New mode starts from phase zero, not the wrapped sum.
                                acc         <= '0;
                                active_mode <= Mode;
                                ModeAck     <= 1'b1;
                                state       <= StRun;
                                Busy        <= 1'b0;
                                drain_cnt   <= '0;
                            end else begin
                                acc       <= sum[ACC_W-1:0];
                                drain_cnt <= drain_cnt + CNT_W'(1);
                            end
                        end
                    end

                    default: begin
                        state <= StRun;
                        Busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
